// File: rtl/morra_cinese_gen2.sv
// ---------------------------------------------------------------------------
// morra_cinese_gen2 -- rock/paper/scissors match referee
//
// Plays rounds between two players and decides the match, either early on a
// score lead or when the configured round limit is reached.
//
// Ports
//   clk      : sole clock, rising edge
//   rst      : synchronous active-high reset
//   INIZIA   : 1 = configure and start a match, 0 = play a round
//   PRIMO    : player-1 move (00 none, 01 rock, 10 paper, 11 scissors);
//              configuration high bits when INIZIA=1
//   SECONDO  : player-2 move, same encoding; configuration low bits
//   MANCHE   : round result, combinational (00 none, 01 P1, 10 P2, 11 draw)
//   PARTITA  : match result, combinational (00 open, 01 P1, 10 P2, 11 draw)
//   SCORE1/2 : registered round-win counts
//   ROUND    : registered count of valid rounds in the current match
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | no match configured, inputs ignored unless INIZIA
// PLAY  | match in progress, valid rounds are scored
// DONE  | match decided, scores held for readout
// ---------------------------------------------------------------------------
module morra_cinese_gen2 #(
  parameter int MIN_ROUNDS   = 4,
  parameter int WIN_MARGIN   = 2,
  parameter int CNT_W        = 5,
  parameter int REPEAT_BLOCK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             INIZIA,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  output logic [1:0]       MANCHE,
  output logic [1:0]       PARTITA,
  output logic [CNT_W-1:0] SCORE1,
  output logic [CNT_W-1:0] SCORE2,
  output logic [CNT_W-1:0] ROUND
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_MIN    = CNT_W'(MIN_ROUNDS);
  localparam logic [CNT_W-1:0] LP_MARGIN = CNT_W'(WIN_MARGIN);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] r_round;
  logic [CNT_W-1:0] r_score1;
  logic [CNT_W-1:0] r_score2;
  logic             r_lw_valid;
  logic             r_lw_p2;
  logic [1:0]       r_lw_move;

  logic             w_repeat;
  logic             w_valid;
  logic             w_draw;
  logic             w_p1_win;
  logic             w_p2_win;
  logic [CNT_W-1:0] w_round_n;
  logic [CNT_W-1:0] w_s1_n;
  logic [CNT_W-1:0] w_s2_n;
  logic [CNT_W-1:0] w_diff;
  logic             w_ended;

  always_comb begin
    // the previous winner may not replay its winning move
    w_repeat  = (REPEAT_BLOCK != 0) && r_lw_valid &&
                ((r_lw_p2 ? SECONDO : PRIMO) == r_lw_move);
    w_valid   = !rst && !INIZIA && (r_state == S_PLAY) &&
                (PRIMO != 2'b00) && (SECONDO != 2'b00) && !w_repeat;
    w_draw    = (PRIMO == SECONDO);
    unique case ({PRIMO, SECONDO})
      4'b01_11, 4'b10_01, 4'b11_10: w_p1_win = 1'b1;
      default:                      w_p1_win = 1'b0;
    endcase
    w_p2_win  = !w_draw && !w_p1_win;
    w_round_n = r_round + LP_ONE;
    w_s1_n    = r_score1 + (w_p1_win ? LP_ONE : '0);
    w_s2_n    = r_score2 + (w_p2_win ? LP_ONE : '0);
    w_diff    = (w_s1_n >= w_s2_n) ? (w_s1_n - w_s2_n) : (w_s2_n - w_s1_n);
    w_ended   = ((w_round_n >= LP_MIN) && (w_diff >= LP_MARGIN)) ||
                (w_round_n == r_limit);

    MANCHE  = 2'b00;
    PARTITA = 2'b00;
    if (w_valid) begin
      if (w_draw)        MANCHE = 2'b11;
      else if (w_p1_win) MANCHE = 2'b01;
      else               MANCHE = 2'b10;
      if (w_ended) begin
        if (w_s1_n > w_s2_n)      PARTITA = 2'b01;
        else if (w_s2_n > w_s1_n) PARTITA = 2'b10;
        else                      PARTITA = 2'b11;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_limit    <= '0;
      r_round    <= '0;
      r_score1   <= '0;
      r_score2   <= '0;
      r_lw_valid <= 1'b0;
      r_lw_p2    <= 1'b0;
      r_lw_move  <= 2'b00;
    end else if (INIZIA) begin
      r_state    <= S_PLAY;
      r_limit    <= CNT_W'({PRIMO, SECONDO}) + LP_MIN;
      r_round    <= '0;
      r_score1   <= '0;
      r_score2   <= '0;
      r_lw_valid <= 1'b0;
      r_lw_p2    <= 1'b0;
      r_lw_move  <= 2'b00;
    end else if (w_valid) begin
      r_round  <= w_round_n;
      r_score1 <= w_s1_n;
      r_score2 <= w_s2_n;
      if (w_draw) begin
        r_lw_valid <= 1'b0;
      end else begin
        r_lw_valid <= 1'b1;
        r_lw_p2    <= w_p2_win;
        r_lw_move  <= w_p2_win ? SECONDO : PRIMO;
      end
      if (w_ended) r_state <= S_DONE;
    end
  end

  assign SCORE1 = r_score1;
  assign SCORE2 = r_score2;
  assign ROUND  = r_round;

endmodule

// File: tb/tb_morra_cinese_gen2.sv
module tb_morra_cinese_gen2;

  localparam int MIN_R  = 4;
  localparam int MARGIN = 2;
  localparam int CW     = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          INIZIA = 1'b0;
  logic [1:0]    PRIMO = 2'b00;
  logic [1:0]    SECONDO = 2'b00;
  logic [1:0]    man_a, par_a, man_b, par_b;
  logic [CW-1:0] s1_a, s2_a, rnd_a, s1_b, s2_b, rnd_b;

  always #5 clk = ~clk;

  morra_cinese_gen2 #(.MIN_ROUNDS(MIN_R), .WIN_MARGIN(MARGIN), .CNT_W(CW), .REPEAT_BLOCK(1)) u_dut (
    .clk(clk), .rst(rst), .INIZIA(INIZIA), .PRIMO(PRIMO), .SECONDO(SECONDO),
    .MANCHE(man_a), .PARTITA(par_a), .SCORE1(s1_a), .SCORE2(s2_a), .ROUND(rnd_a));

  morra_cinese_gen2 #(.MIN_ROUNDS(MIN_R), .WIN_MARGIN(MARGIN), .CNT_W(CW), .REPEAT_BLOCK(0)) u_dut_nb (
    .clk(clk), .rst(rst), .INIZIA(INIZIA), .PRIMO(PRIMO), .SECONDO(SECONDO),
    .MANCHE(man_b), .PARTITA(par_b), .SCORE1(s1_b), .SCORE2(s2_b), .ROUND(rnd_b));

  // behavioural model of a match: 0 idle, 1 playing, 2 decided
  typedef struct {
    bit known;
    int st;
    int limit, r, s1, s2;
    bit lw_v;
    int lw_who;  // 1 or 2
    int lw_mv;
  } mdl_t;

  typedef struct {
    bit regs_known;
    int man, par, s1, s2, rnd;
  } exp_t;

  mdl_t ma, mb;
  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic model_step(input mdl_t m, input bit rst_v, input bit ini,
                            input int p1, input int p2, input bit rb,
                            output mdl_t mn, output exp_t e);
    int  winner;
    int  lead;
    bit  ok;
    mn = m;
    e.regs_known = m.known;
    e.s1 = m.s1; e.s2 = m.s2; e.rnd = m.r;
    e.man = 0; e.par = 0;
    if (rst_v) begin
      mn.known = 1; mn.st = 0; mn.limit = 0; mn.r = 0; mn.s1 = 0; mn.s2 = 0;
      mn.lw_v = 0; mn.lw_who = 0; mn.lw_mv = 0;
    end else if (ini) begin
      mn.st = 1; mn.limit = p1 * 4 + p2 + MIN_R; mn.r = 0; mn.s1 = 0; mn.s2 = 0;
      mn.lw_v = 0;
    end else if (m.st == 1) begin
      ok = (p1 != 0) && (p2 != 0);
      if (rb && m.lw_v && ((m.lw_who == 1 ? p1 : p2) == m.lw_mv)) ok = 0;
      if (ok) begin
        // rock=1 paper=2 scissors=3: a move beats the one just below it mod 3
        if (p1 == p2) winner = 0;
        else if ((p1 - p2 + 3) % 3 == 1) winner = 1;
        else winner = 2;
        e.man = (winner == 0) ? 3 : winner;
        mn.r = m.r + 1;
        if (winner == 1) mn.s1 = m.s1 + 1;
        if (winner == 2) mn.s2 = m.s2 + 1;
        mn.lw_v = (winner != 0);
        mn.lw_who = winner;
        mn.lw_mv = (winner == 1) ? p1 : p2;
        lead = mn.s1 - mn.s2;
        if (lead < 0) lead = -lead;
        if ((mn.r >= MIN_R && lead >= MARGIN) || mn.r == m.limit) begin
          e.par = (mn.s1 > mn.s2) ? 1 : (mn.s2 > mn.s1) ? 2 : 3;
          mn.st = 2;
        end
      end
    end
  endtask

  task automatic drive(input bit rst_v, input bit ini, input int p1, input int p2);
    mdl_t na, nb;
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst = rst_v; INIZIA = ini; PRIMO = 2'(p1); SECONDO = 2'(p2);
    model_step(ma, rst_v, ini, p1, p2, 1'b1, na, ea);
    model_step(mb, rst_v, ini, p1, p2, 1'b0, nb, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    ma = na;
    mb = nb;
  endtask

  task automatic play(input int p1, input int p2);
    drive(1'b0, 1'b0, p1, p2);
  endtask

  task automatic start(input int cfg);
    drive(1'b0, 1'b1, cfg / 4, cfg % 4);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
  endtask

  exp_t mon_a, mon_b;
  always @(negedge clk) begin
    if (q_a.size() > 0 && q_b.size() > 0) begin
      mon_a = q_a.pop_front();
      mon_b = q_b.pop_front();
      chk("manche_rb1", 32'(man_a), 32'(mon_a.man));
      chk("partita_rb1", 32'(par_a), 32'(mon_a.par));
      chk("manche_rb0", 32'(man_b), 32'(mon_b.man));
      chk("partita_rb0", 32'(par_b), 32'(mon_b.par));
      if (mon_a.regs_known) begin
        chk("score1_rb1", 32'(s1_a), 32'(mon_a.s1));
        chk("score2_rb1", 32'(s2_a), 32'(mon_a.s2));
        chk("round_rb1", 32'(rnd_a), 32'(mon_a.rnd));
      end
      if (mon_b.regs_known) begin
        chk("score1_rb0", 32'(s1_b), 32'(mon_b.s1));
        chk("score2_rb0", 32'(s2_b), 32'(mon_b.s2));
        chk("round_rb0", 32'(rnd_b), 32'(mon_b.rnd));
      end
    end
  end

  initial begin
    int r;
    int waited;
    ma = '{default: 0};
    mb = '{default: 0};

    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 1, 2);
    // idle: rounds ignored
    play(1, 2); play(1, 2);

    // P2 wins 1-3 on round 4, then decided state ignores rounds
    start(1);
    play(1, 2); play(3, 1); play(2, 3); play(3, 2);
    play(1, 3); play(2, 2);

    // two draws then 0-2
    start(1);
    play(3, 3); play(3, 3); play(3, 1); play(2, 3); play(1, 1);

    // draws, then 1-1 at the limit
    start(1);
    play(3, 3); play(3, 3); play(3, 3); play(3, 1); play(1, 3);

    // no-repeat: P2 rock win, empty move, then P2 replays rock
    start(1);
    play(3, 1); play(0, 2); play(1, 1); play(2, 1); play(2, 3);

    // restart mid-match, reset mid-match, reset together with start
    start(15);
    play(1, 2); play(2, 1);
    start(3);
    play(1, 3); play(2, 2);
    drive(1'b1, 1'b0, 1, 3);
    play(1, 3);
    start(0);
    play(2, 1);
    drive(1'b1, 1'b1, 2, 2);
    play(1, 3); play(3, 2);

    // randomized matches
    start(0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       drive(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3));
      else if (r < 10) start($urandom_range(0, 15));
      else if (r < 20) play($urandom_range(0, 3), $urandom_range(0, 3));
      else             play($urandom_range(1, 3), $urandom_range(1, 3));
    end

    drive(1'b0, 1'b0, 0, 0);
    waited = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", q_a.size() + q_b.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/morra_cinese_gen2.md
MORRA_CINESE_GEN2 -- requirements
Module: morra_cinese_gen2

Interface
REQ-001 Parameter MIN_ROUNDS, default 4: constant added to the 4-bit configuration to form the round limit; also the minimum valid rounds before an early win.
REQ-002 Parameter WIN_MARGIN, default 2: score lead that ends the match early; legal range 1..MIN_ROUNDS.
REQ-003 Parameter CNT_W, default 5: width of round and score counters; SHALL satisfy 2**CNT_W > 15+MIN_ROUNDS.
REQ-004 Parameter REPEAT_BLOCK, default 1: 1 enables the no-repeat rule (REQ-016); 0 disables it.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 INIZIA  input  1  1 = configure and start a new match this cycle; 0 = play a round.
REQ-008 PRIMO  input  2  player-1 move (00 none, 01 rock, 10 paper, 11 scissors); configuration high bits when INIZIA=1.
REQ-009 SECONDO  input  2  player-2 move, same encoding; configuration low bits when INIZIA=1.
REQ-010 MANCHE  output  2  round result: 00 invalid/no round, 01 P1, 10 P2, 11 draw.
REQ-011 PARTITA  output  2  match result: 00 not ended, 01 P1, 10 P2, 11 draw.
REQ-012 SCORE1, SCORE2  output  CNT_W  registered round-win counts.
REQ-013 ROUND  output  CNT_W  registered count of valid rounds played in the current match.

Function
REQ-014 States: IDLE (no match), PLAY, DONE; MANCHE/PARTITA SHALL be combinational (Mealy) from current state and inputs, valid in the same cycle; all state commits on the next rising edge.
REQ-015 INIZIA=1 in any state: MANCHE=00, PARTITA=00; next edge loads LIMIT={PRIMO,SECONDO}+MIN_ROUNDS, clears SCORE1/SCORE2/ROUND and the last-winner record, enters PLAY.
REQ-016 In PLAY with INIZIA=0 a round is valid iff PRIMO!=00, SECONDO!=00, and (REPEAT_BLOCK=0 or no last winner recorded or the last winner's current move differs from its recorded winning move).
REQ-017 Invalid round: MANCHE=00, PARTITA=00, no register changes (round not counted, last-winner record kept).
REQ-018 Valid round: MANCHE per rock>scissors>paper>rock, equal moves = 11; next edge increments ROUND and the winner's score; a win records {winner, move}; a draw clears the record.
REQ-019 End test on post-round values R', S1', S2': ended iff (R'>=MIN_ROUNDS and |S1'-S2'|>=WIN_MARGIN) or R'==LIMIT.
REQ-020 On ended: PARTITA = 01 if S1'>S2', 10 if S2'>S1', 11 if equal, in the same cycle as the deciding MANCHE; next edge enters DONE.
REQ-021 IDLE and DONE with INIZIA=0: MANCHE=00, PARTITA=00, all registers hold (scores/ROUND remain readable in DONE).
REQ-022 Counters SHALL never wrap: LIMIT bounded by REQ-003, ROUND stops at LIMIT via REQ-020.

Reset
REQ-023 rst=1 at an edge: state IDLE, SCORE1=SCORE2=ROUND=0, LIMIT=0, last-winner record cleared; rst SHALL override simultaneous INIZIA and any round in progress.
REQ-024 While rst=1 the combinational outputs SHALL be MANCHE=00, PARTITA=00.

Verification (defaults)
REQ-025 rst, then INIZIA=0 PRIMO=01 SECONDO=10 -> MANCHE=00, PARTITA=00, ROUND stays 0.
REQ-026 INIZIA cfg 00/01 (LIMIT 5); rounds 01v10, 11v01, 10v11, 11v10 -> MANCHE 10,10,10,01; PARTITA 00,00,00,10 on round 4; SCORE 1/3, then DONE outputs 00/00.
REQ-027 LIMIT 5; 11v11, 11v11, 11v01, 10v11 -> MANCHE 11,11,10,10; PARTITA 10 on round 4 (0-2 margin).
REQ-028 LIMIT 5; three 11v11 draws, 11v01 (P2 wins rock), 01v11 -> final MANCHE 01, PARTITA 11 (1-1 at LIMIT).
REQ-029 No-repeat: P2 wins 11v01, then 00v10 -> 00 (not counted), then 01v01 -> MANCHE 00, ROUND unchanged; with REPEAT_BLOCK=0 the same 01v01 -> MANCHE 11.
REQ-030 Mid-match INIZIA with new cfg and mid-match rst both clear scores/ROUND at the next edge; rst asserted together with INIZIA leaves state IDLE.
